// File: rtl/aes_key_expand_seq_if.sv
// aes_key_expand_seq_if: key-load and round-key stream bundle for the AES-128
// forward key-expansion engine.
//   master: the key source / round-key consumer (drives key_*_i, abort_i, rkey_ready_i)
//   slave : the expansion engine (drives key_ready_o, rkey_*_o, key_last_*_o)
// The decryption hand-off signals exist only when AES_KEY_EXPAND_DEC_HANDOFF_EN is defined.
interface aes_key_expand_seq_if;
    logic         key_valid_i;
    logic         key_ready_o;
    logic [127:0] key_i;
    logic         abort_i;
    logic         rkey_valid_o;
    logic         rkey_ready_i;
    logic [127:0] rkey_o;
    logic [3:0]   rkey_round_o;
`ifdef AES_KEY_EXPAND_DEC_HANDOFF_EN
    logic [127:0] key_last_o;
    logic [7:0]   key_last_rcon_o;
    logic         key_last_valid_o;

    modport master (
        output key_valid_i, key_i, abort_i, rkey_ready_i,
        input  key_ready_o, rkey_valid_o, rkey_o, rkey_round_o,
        input  key_last_o, key_last_rcon_o, key_last_valid_o
    );

    modport slave (
        input  key_valid_i, key_i, abort_i, rkey_ready_i,
        output key_ready_o, rkey_valid_o, rkey_o, rkey_round_o,
        output key_last_o, key_last_rcon_o, key_last_valid_o
    );
`else
    modport master (
        output key_valid_i, key_i, abort_i, rkey_ready_i,
        input  key_ready_o, rkey_valid_o, rkey_o, rkey_round_o
    );

    modport slave (
        input  key_valid_i, key_i, abort_i, rkey_ready_i,
        output key_ready_o, rkey_valid_o, rkey_o, rkey_round_o
    );
`endif
endinterface

// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: iterative AES-128 forward key expansion. Accepts a cipher
// key over a valid/ready handshake and streams round keys 0..10, one per
// accepted handshake, on a registered valid/ready output.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - aes_key_expand_seq_if.slave (key load, abort, round-key stream)
// Optional feature macro: AES_KEY_EXPAND_DEC_HANDOFF_EN exports the round-10
// key and its rcon (8'h36) to seed the decryption key schedule.

// aes_sbox: AES forward S-box computed as GF(2^8) inverse followed by the affine map.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        return gf_mul(x127, x127);
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv      = gf_inv(in_byte);
        out_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end
endmodule

module aes_key_expand_seq (
    input  logic                 clk,
    input  logic                 rst,
    aes_key_expand_seq_if.slave  bus
);
    localparam int unsigned KEY_W     = 128;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned ROUND_W   = 4;
    localparam int unsigned RCON_W    = 8;
    localparam int unsigned LAST_RND  = 10;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e              state_q, state_d;
    logic [KEY_W-1:0]    rkey_q, rkey_d;
    logic [ROUND_W-1:0]  round_q, round_d;
    logic [RCON_W-1:0]   rcon_q, rcon_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
`ifdef AES_KEY_EXPAND_DEC_HANDOFF_EN
    logic [KEY_W-1:0]    last_key_q, last_key_d;
    logic [RCON_W-1:0]   last_rcon_q, last_rcon_d;
    logic                last_valid_q, last_valid_d;
`endif

    // Round function: t = SubWord(RotWord(w3)) ^ rcon, then the w0..w3 xor chain.
    logic [WORD_W-1:0]   w3_rot;
    logic [WORD_W-1:0]   w3_sub;
    logic [WORD_W-1:0]   t_word;
    logic [WORD_W-1:0]   nw0, nw1, nw2, nw3;
    logic [KEY_W-1:0]    rkey_next;
    logic [RCON_W-1:0]   rcon_next;

    assign w3_rot = {rkey_q[23:0], rkey_q[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (w3_rot[b*8 +: 8]),
            .out_byte (w3_sub[b*8 +: 8])
        );
    end

    always_comb begin
        t_word    = w3_sub ^ {rcon_q, 24'h000000};
        nw0       = rkey_q[127:96] ^ t_word;
        nw1       = rkey_q[95:64]  ^ nw0;
        nw2       = rkey_q[63:32]  ^ nw1;
        nw3       = rkey_q[31:0]   ^ nw2;
        rkey_next = {nw0, nw1, nw2, nw3};
        rcon_next = rcon_q[7] ? ({rcon_q[6:0], 1'b0} ^ 8'h1b) : {rcon_q[6:0], 1'b0};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        rkey_d  = rkey_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        valid_d = valid_q;
        ready_d = ready_q;
`ifdef AES_KEY_EXPAND_DEC_HANDOFF_EN
        last_key_d   = last_key_q;
        last_rcon_d  = last_rcon_q;
        last_valid_d = last_valid_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.key_valid_i) begin
                    state_d = RUN;
                    rkey_d  = bus.key_i;
                    round_d = '0;
                    rcon_d  = 8'h01;
                    valid_d = 1'b1;
                    ready_d = 1'b0;
`ifdef AES_KEY_EXPAND_DEC_HANDOFF_EN
                    last_valid_d = 1'b0;
`endif
                end
            end
            RUN: begin
                // Abort takes priority over a simultaneous round-key handshake.
                if (bus.abort_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
`ifdef AES_KEY_EXPAND_DEC_HANDOFF_EN
                    last_valid_d = 1'b0;
`endif
                end else if (bus.rkey_ready_i) begin
                    if (round_q == ROUND_W'(LAST_RND)) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        rkey_d  = rkey_next;
                        round_d = round_q + ROUND_W'(1);
                        rcon_d  = rcon_next;
`ifdef AES_KEY_EXPAND_DEC_HANDOFF_EN
                        // Capture the round-10 key as it is produced.
                        if (round_q == ROUND_W'(LAST_RND - 1)) begin
                            last_key_d   = rkey_next;
                            last_rcon_d  = rcon_q;
                            last_valid_d = 1'b1;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rkey_q  <= '0;
            round_q <= '0;
            rcon_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            rkey_q  <= rkey_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

`ifdef AES_KEY_EXPAND_DEC_HANDOFF_EN
    // Decryption hand-off registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_key_q   <= '0;
            last_rcon_q  <= '0;
            last_valid_q <= 1'b0;
        end else begin
            last_key_q   <= last_key_d;
            last_rcon_q  <= last_rcon_d;
            last_valid_q <= last_valid_d;
        end
    end

    assign bus.key_last_o       = last_key_q;
    assign bus.key_last_rcon_o  = last_rcon_q;
    assign bus.key_last_valid_o = last_valid_q;
`endif

    // Ready is held low while reset is asserted, then idles high.
    assign bus.key_ready_o  = ready_q & ~rst;
    assign bus.rkey_valid_o = valid_q;
    assign bus.rkey_o       = rkey_q;
    assign bus.rkey_round_o = round_q;
endmodule
